// File: rtl/ball_kinematics_if.sv
// ball_kinematics_if: control/data bundle between the launch generator (master)
// and the ball_kinematics integrator (slave).
//   master drives : i_refresh, i_launch, i_launch_x, i_vel_x/y/z, i_hold, i_clear
//   slave drives  : o_x_pos, o_y_pos, o_z_pos, o_state, o_bounce_cnt,
//                   o_bounce, o_landed, o_done
// W/FRAC/MAX_BOUNCES must match the parameters of the attached ball_kinematics.
interface ball_kinematics_if #(
  parameter int W           = 16,
  parameter int FRAC        = 2,
  parameter int MAX_BOUNCES = 2
);
  localparam int BCW = (MAX_BOUNCES > 0) ? $clog2(MAX_BOUNCES + 1) : 1;

  logic                   i_refresh;
  logic                   i_launch;
  logic [15:0]            i_launch_x;
  logic signed [W-1:0]    i_vel_x;
  logic signed [W-1:0]    i_vel_y;
  logic signed [W-1:0]    i_vel_z;
  logic                   i_hold;
  logic                   i_clear;

  logic signed [W-FRAC:0]   o_x_pos;
  logic signed [W-FRAC:0]   o_y_pos;
  logic signed [W-FRAC-1:0] o_z_pos;
  logic [1:0]               o_state;
  logic [BCW-1:0]           o_bounce_cnt;
  logic                     o_bounce;
  logic                     o_landed;
  logic                     o_done;

  modport master (
    output i_refresh, i_launch, i_launch_x, i_vel_x, i_vel_y, i_vel_z, i_hold, i_clear,
    input  o_x_pos, o_y_pos, o_z_pos, o_state, o_bounce_cnt, o_bounce, o_landed, o_done
  );

  modport slave (
    input  i_refresh, i_launch, i_launch_x, i_vel_x, i_vel_y, i_vel_z, i_hold, i_clear,
    output o_x_pos, o_y_pos, o_z_pos, o_state, o_bounce_cnt, o_bounce, o_landed, o_done
  );
endinterface

// File: rtl/ball_kinematics.sv
// ball_kinematics: per-frame projectile integrator for the ball sprite.
// Advances position/velocity once per i_refresh strobe, applies x/y drag toward
// zero, gravity on z, rebounds off the ground with restitution up to
// MAX_BOUNCES times, then rests for REST_FRAMES frames before auto-clearing.
// Ports:
//   i_clk   : clock
//   i_rst_n : synchronous active-low reset
//   bus     : ball_kinematics_if.slave (launch/velocity/control in,
//             projected coordinates, state, bounce count and event pulses out)
module ball_kinematics #(
  parameter int W            = 16,
  parameter int FRAC         = 2,
  parameter int X_ORIGIN     = 1590,
  parameter int X_ACC        = 1,
  parameter int Y_ACC        = 0,
  parameter int Z_ACC        = 3,
  parameter int MAX_BOUNCES  = 2,
  parameter int BOUNCE_SHIFT = 1,
  parameter int REST_FRAMES  = 60
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  ball_kinematics_if.slave  bus
);
  localparam int BCW = (MAX_BOUNCES > 0) ? $clog2(MAX_BOUNCES + 1) : 1;
  localparam int RCW = (REST_FRAMES > 0) ? $clog2(REST_FRAMES + 1) : 1;

  localparam logic signed [W:0]   XACC = (W+1)'(X_ACC);
  localparam logic signed [W:0]   YACC = (W+1)'(Y_ACC);
  localparam logic signed [W-1:0] ZACC = W'(Z_ACC);
  localparam logic signed [W-1:0] XORG = W'(X_ORIGIN);
  localparam logic [BCW-1:0]      MAXB = BCW'(MAX_BOUNCES);
  localparam logic [RCW-1:0]      RFR  = RCW'(REST_FRAMES);

  typedef enum logic [1:0] {IDLE = 2'd0, FLIGHT = 2'd1, REST = 2'd2} state_e;

  state_e              state_q, state_d;
  logic signed [W-1:0] x_pos_q, x_pos_d, y_pos_q, y_pos_d, z_pos_q, z_pos_d;
  logic signed [W-1:0] x_vel_q, x_vel_d, y_vel_q, y_vel_d, z_vel_q, z_vel_d;
  logic [BCW-1:0]      bcnt_q, bcnt_d;
  logic [RCW-1:0]      rcnt_q, rcnt_d;
  logic                bounce_q, bounce_d, landed_q, landed_d, done_q, done_d;

  logic signed [W-1:0] z_next, z_reb;
  logic signed [W:0]   y_sum;

  // Drag toward zero: anything within one step of zero stops dead rather than
  // overshooting to the other sign. Magnitude taken in W+1 bits so the most
  // negative value still compares correctly.
  function automatic logic signed [W-1:0] drag(input logic signed [W-1:0] v,
                                               input logic signed [W:0]   acc);
    logic signed [W:0] ve, mag, t;
    ve  = (W+1)'(v);
    mag = (ve < 0) ? -ve : ve;
    t   = (ve < 0) ? ve + acc : ve - acc;
    drag = (mag <= acc) ? '0 : t[W-1:0];
  endfunction

  assign z_next = z_pos_q + z_vel_q;
  assign z_reb  = (-z_vel_q) >>> BOUNCE_SHIFT;

  always_comb begin
    state_d  = state_q;
    x_pos_d  = x_pos_q;  y_pos_d = y_pos_q;  z_pos_d = z_pos_q;
    x_vel_d  = x_vel_q;  y_vel_d = y_vel_q;  z_vel_d = z_vel_q;
    bcnt_d   = bcnt_q;
    rcnt_d   = rcnt_q;
    bounce_d = 1'b0;
    landed_d = 1'b0;
    done_d   = 1'b0;

    if (bus.i_launch) begin
      // Reloads every cycle while held, so a level launch freezes the ball.
      state_d = FLIGHT;
      x_pos_d = W'(bus.i_launch_x) - XORG;
      y_pos_d = '0;
      z_pos_d = '0;
      x_vel_d = bus.i_vel_x;
      y_vel_d = bus.i_vel_y;
      z_vel_d = bus.i_vel_z;
      bcnt_d  = '0;
      rcnt_d  = '0;
    end else if (bus.i_clear) begin
      state_d = IDLE;
      x_pos_d = '0;  y_pos_d = '0;  z_pos_d = '0;
      x_vel_d = '0;  y_vel_d = '0;  z_vel_d = '0;
      bcnt_d  = '0;
      rcnt_d  = '0;
    end else if (bus.i_refresh) begin
      unique case (state_q)
        FLIGHT: begin
          x_pos_d = x_pos_q + x_vel_q;
          y_pos_d = y_pos_q + y_vel_q;
          x_vel_d = drag(x_vel_q, XACC);
          y_vel_d = drag(y_vel_q, YACC);
          if (!z_next[W-1]) begin
            z_pos_d = z_next;
            z_vel_d = z_vel_q - ZACC;
          end else if (bcnt_q < MAXB && z_reb != '0) begin
            z_pos_d  = '0;
            z_vel_d  = z_reb;
            bcnt_d   = bcnt_q + BCW'(1);
            bounce_d = 1'b1;
          end else begin
            // Too many contacts or rebound too weak to leave the ground.
            state_d  = REST;
            z_pos_d  = '0;
            x_vel_d  = '0;  y_vel_d = '0;  z_vel_d = '0;
            rcnt_d   = '0;
            landed_d = 1'b1;
            if (bcnt_q < MAXB) bcnt_d = bcnt_q + BCW'(1);
          end
        end
        REST: begin
          if (rcnt_q == RFR && !bus.i_hold) begin
            // Auto-clear: position and contact count return to zero so all
            // outputs read zero once idle.
            state_d = IDLE;
            x_pos_d = '0;  y_pos_d = '0;  z_pos_d = '0;
            bcnt_d  = '0;
            rcnt_d  = '0;
            done_d  = 1'b1;
          end else if (rcnt_q < RFR) begin
            rcnt_d = rcnt_q + RCW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      x_pos_q  <= '0;  y_pos_q <= '0;  z_pos_q <= '0;
      x_vel_q  <= '0;  y_vel_q <= '0;  z_vel_q <= '0;
      bcnt_q   <= '0;
      rcnt_q   <= '0;
      bounce_q <= 1'b0;
      landed_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_pos_q  <= x_pos_d;  y_pos_q <= y_pos_d;  z_pos_q <= z_pos_d;
      x_vel_q  <= x_vel_d;  y_vel_q <= y_vel_d;  z_vel_q <= z_vel_d;
      bcnt_q   <= bcnt_d;
      rcnt_q   <= rcnt_d;
      bounce_q <= bounce_d;
      landed_q <= landed_d;
      done_q   <= done_d;
    end
  end

  // Screen projection: height lifts the sprite by half its value on y.
  assign y_sum = (W+1)'(y_pos_q) + (W+1)'(z_pos_q >>> 1);

  assign bus.o_x_pos      = (W-FRAC+1)'(x_pos_q >>> FRAC);
  assign bus.o_y_pos      = (W-FRAC+1)'(y_sum >>> FRAC);
  assign bus.o_z_pos      = (W-FRAC)'(z_pos_q >>> FRAC);
  assign bus.o_state      = state_q;
  assign bus.o_bounce_cnt = bcnt_q;
  assign bus.o_bounce     = bounce_q;
  assign bus.o_landed     = landed_q;
  assign bus.o_done       = done_q;
endmodule

// File: tb/tb_ball_kinematics.sv
// Testbench for ball_kinematics: hand-derived vector table, directed corner
// sequences, and randomized traffic against an integer reference model.
module tb_ball_kinematics;
  localparam int W = 16, FRAC = 2, XO = 1590, XA = 1, YA = 0, ZA = 3;
  localparam int MB = 2, BS = 1, RF = 60;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;

  ball_kinematics_if #(.W(W), .FRAC(FRAC), .MAX_BOUNCES(MB)) bus ();

  ball_kinematics #(
    .W(W), .FRAC(FRAC), .X_ORIGIN(XO), .X_ACC(XA), .Y_ACC(YA), .Z_ACC(ZA),
    .MAX_BOUNCES(MB), .BOUNCE_SHIFT(BS), .REST_FRAMES(RF)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus)
  );

  always #5 i_clk = ~i_clk;

  int total = 0, bad = 0;

  // Reference model state (plain integers).
  int mx, my, mz, mvx, mvy, mvz, mst, mbc, mrc;
  int mb, ml, md;
  int last_bounce, last_landed, last_done;

  function automatic int wrap(input int v);
    logic signed [W-1:0] t;
    t = v[W-1:0];
    return int'(t);
  endfunction

  function automatic int fdiv(input int a, input int d);
    int q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int mdrag(input int v, input int acc);
    int mag;
    mag = (v < 0) ? -v : v;
    if (mag <= acc) return 0;
    return wrap((v > 0) ? v - acc : v + acc);
  endfunction

  task automatic model_step();
    int zn, r;
    mb = 0; ml = 0; md = 0;
    if (!i_rst_n) begin
      mx = 0; my = 0; mz = 0; mvx = 0; mvy = 0; mvz = 0; mst = 0; mbc = 0; mrc = 0;
    end else if (bus.i_launch) begin
      mx = wrap(int'(bus.i_launch_x) - XO); my = 0; mz = 0;
      mvx = int'(bus.i_vel_x); mvy = int'(bus.i_vel_y); mvz = int'(bus.i_vel_z);
      mst = 1; mbc = 0; mrc = 0;
    end else if (bus.i_clear) begin
      mx = 0; my = 0; mz = 0; mvx = 0; mvy = 0; mvz = 0; mst = 0; mbc = 0; mrc = 0;
    end else if (bus.i_refresh) begin
      if (mst == 1) begin
        mx = wrap(mx + mvx);
        my = wrap(my + mvy);
        mvx = mdrag(mvx, XA);
        mvy = mdrag(mvy, YA);
        zn = wrap(mz + mvz);
        if (zn >= 0) begin
          mz = zn; mvz = wrap(mvz - ZA);
        end else begin
          r = fdiv(wrap(-mvz), 1 << BS);
          mz = 0;
          if (mbc < MB && r != 0) begin
            mvz = r; mbc++; mb = 1;
          end else begin
            mvx = 0; mvy = 0; mvz = 0; mst = 2; mrc = 0; ml = 1;
            if (mbc < MB) mbc++;
          end
        end
      end else if (mst == 2) begin
        if (mrc == RF && !bus.i_hold) begin
          mst = 0; mx = 0; my = 0; mz = 0; mbc = 0; mrc = 0; md = 1;
        end else if (mrc < RF) mrc++;
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    check("x_pos",  int'(bus.o_x_pos), fdiv(mx, 1 << FRAC));
    check("y_pos",  int'(bus.o_y_pos), fdiv(my + fdiv(mz, 2), 1 << FRAC));
    check("z_pos",  int'(bus.o_z_pos), fdiv(mz, 1 << FRAC));
    check("state",  int'(bus.o_state), mst);
    check("bcnt",   int'(bus.o_bounce_cnt), mbc);
    check("bounce", int'(bus.o_bounce), mb);
    check("landed", int'(bus.o_landed), ml);
    check("done",   int'(bus.o_done), md);
  endtask

  // One clock edge with the current inputs; model advanced in lock-step.
  task automatic step();
    model_step();
    @(posedge i_clk);
    #1;
    check_all();
  endtask

  // One frame strobe followed by one quiet cycle; pulses latched for checks.
  task automatic tick();
    bus.i_refresh = 1'b1;
    step();
    last_bounce = int'(bus.o_bounce);
    last_landed = int'(bus.o_landed);
    last_done   = int'(bus.o_done);
    bus.i_refresh = 1'b0;
    step();
  endtask

  task automatic launch(input int lx, input int vx, input int vy, input int vz);
    bus.i_launch   = 1'b1;
    bus.i_launch_x = 16'(lx);
    bus.i_vel_x    = W'(vx);
    bus.i_vel_y    = W'(vy);
    bus.i_vel_z    = W'(vz);
    step();
    bus.i_launch = 1'b0;
  endtask

  typedef struct {
    int lx, vx, vy, vz, ticks;
    int ex, ey, ez, est, ebc;
  } vec_t;

  vec_t vt[8];

  initial begin
    bus.i_refresh = 0; bus.i_launch = 0; bus.i_launch_x = '0;
    bus.i_vel_x = '0; bus.i_vel_y = '0; bus.i_vel_z = '0;
    bus.i_hold = 0; bus.i_clear = 0;

    // Outputs are raw (o_x, o_y, o_z), i.e. already shifted by FRAC.
    vt[0] = '{1590,  4, 0, 9,  4,   2,  2, 4, 1, 0};
    vt[1] = '{1590,  4, 0, 9,  8,   2,  0, 0, 1, 1};
    vt[2] = '{1590,  4, 0, 9, 14,   2,  0, 0, 1, 2};
    vt[3] = '{1590,  4, 0, 9, 18,   2,  0, 0, 2, 2};
    vt[4] = '{1600, -3, 8, 0,  1,   1,  2, 0, 1, 0};
    vt[5] = '{1590,  0, 0, 0,  2,   0,  0, 0, 1, 1};
    vt[6] = '{1580, -1,-5, 2,  1,  -3, -1, 0, 1, 0};
    vt[7] = '{1590,  0, 0, 0,  6,   0,  0, 0, 2, 2};

    // Reset dominates a simultaneous launch.
    i_rst_n = 1'b0;
    bus.i_launch = 1'b1; bus.i_launch_x = 16'd1590; bus.i_vel_x = 4; bus.i_vel_z = 9;
    step();
    check("rst_state", int'(bus.o_state), 0);
    check("rst_x", int'(bus.o_x_pos), 0);
    i_rst_n = 1'b1;
    step();
    check("launch_after_rst", int'(bus.o_state), 1);
    bus.i_launch = 1'b0;

    // Vector table.
    foreach (vt[k]) begin
      launch(vt[k].lx, vt[k].vx, vt[k].vy, vt[k].vz);
      for (int t = 0; t < vt[k].ticks; t++) tick();
      check($sformatf("vec%0d_x", k),   int'(bus.o_x_pos), vt[k].ex);
      check($sformatf("vec%0d_y", k),   int'(bus.o_y_pos), vt[k].ey);
      check($sformatf("vec%0d_z", k),   int'(bus.o_z_pos), vt[k].ez);
      check($sformatf("vec%0d_st", k),  int'(bus.o_state), vt[k].est);
      check($sformatf("vec%0d_bc", k),  int'(bus.o_bounce_cnt), vt[k].ebc);
    end

    // Full flight: bounce pulses at ticks 8 and 14, landing at 18.
    launch(1590, 4, 0, 9);
    for (int t = 1; t <= 18; t++) begin
      tick();
      if (t == 8 || t == 14) check($sformatf("bounce_t%0d", t), last_bounce, 1);
      if (t == 7)  check("no_bounce_t7", last_bounce, 0);
      if (t == 18) check("landed_t18", last_landed, 1);
    end

    // Held in REST well past REST_FRAMES.
    bus.i_hold = 1'b1;
    for (int t = 0; t < 100; t++) tick();
    check("hold_state", int'(bus.o_state), 2);
    check("hold_x", int'(bus.o_x_pos), 2);
    bus.i_hold = 1'b0;
    tick();
    check("done_pulse", last_done, 1);
    check("done_state", int'(bus.o_state), 0);
    check("done_x", int'(bus.o_x_pos), 0);

    // Launch beats clear mid-flight.
    launch(1590, 4, 0, 9);
    tick(); tick(); tick();
    bus.i_clear = 1'b1; bus.i_launch = 1'b1; bus.i_launch_x = 16'd1610;
    step();
    check("launch_wins_st", int'(bus.o_state), 1);
    check("launch_wins_x", int'(bus.o_x_pos), 5);
    bus.i_clear = 1'b0; bus.i_launch = 1'b0;

    // Clear in REST: idle, no done pulse.
    launch(1590, 0, 0, 0);
    for (int t = 0; t < 6; t++) tick();
    check("rest_before_clear", int'(bus.o_state), 2);
    bus.i_clear = 1'b1;
    step();
    check("clear_state", int'(bus.o_state), 0);
    check("clear_no_done", int'(bus.o_done), 0);
    bus.i_clear = 1'b0;

    // Refresh in IDLE changes nothing.
    tick();
    check("idle_refresh_st", int'(bus.o_state), 0);
    check("idle_refresh_x", int'(bus.o_x_pos), 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      i_rst_n       = ($urandom_range(0, 999) != 0);
      bus.i_launch  = ($urandom_range(0, 59) == 0);
      bus.i_clear   = ($urandom_range(0, 299) == 0);
      bus.i_refresh = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 49) == 0) bus.i_hold = ~bus.i_hold;
      bus.i_launch_x = 16'($urandom_range(1400, 1800));
      bus.i_vel_x = W'(int'($urandom_range(0, 40)) - 20);
      bus.i_vel_y = W'(int'($urandom_range(0, 40)) - 20);
      bus.i_vel_z = W'(int'($urandom_range(0, 60)) - 20);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ball_kinematics.md
Name: ball_kinematics

Overview:
Parametrised per-frame projectile integrator for the ball sprite, and the successor to the single-landing motion block. It adds multi-bounce with restitution, velocity drag that saturates at zero, and an explicit state machine with rest/settle timing. It sits between the launch/speed generator (mouse input) and the renderer/collision logic. It advances once per display frame (i_refresh strobe) and outputs projected screen coordinates.

Parameters:
W, 16, signed width of internal position/velocity registers
FRAC, 2, fractional bits dropped on output (output = pos >>> FRAC)
X_ORIGIN, 1590, subtracted from i_launch_x at launch
X_ACC, 1, x drag magnitude per frame (unsigned, toward zero)
Y_ACC, 0, y drag magnitude per frame (unsigned, toward zero)
Z_ACC, 3, gravity per frame (always subtracted from z_vel)
MAX_BOUNCES, 2, ground contacts that rebound before final landing (0 = land on first contact)
BOUNCE_SHIFT, 1, rebound z_vel = (-z_vel) >>> BOUNCE_SHIFT
REST_FRAMES, 60, frames held at rest before auto-clear

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  reset, synchronous, active-low
i_refresh  in  1  one-cycle frame strobe; all motion updates happen only on cycles where it is high
i_launch  in  1  start a flight (level or pulse; sampled every cycle)
i_launch_x  in  16  raw mouse x at launch
i_vel_x, i_vel_y, i_vel_z  in  W each  signed initial velocities
i_hold  in  1  collision engine busy; blocks auto-clear at end of REST
i_clear  in  1  collision done; forces IDLE
o_x_pos  out  W-FRAC+1  signed, x_pos >>> FRAC
o_y_pos  out  W-FRAC+1  signed, (y_pos + (z_pos >>> 1)) >>> FRAC, sum formed in W+1 bits
o_z_pos  out  W-FRAC  signed, z_pos >>> FRAC
o_state  out  2  IDLE=0, FLIGHT=1, REST=2
o_bounce_cnt  out  $clog2(MAX_BOUNCES+1)  ground contacts this flight (clog2 min 1 bit)
o_bounce  out  1  one-cycle pulse on each rebound
o_landed  out  1  one-cycle pulse on FLIGHT->REST
o_done  out  1  one-cycle pulse on REST->IDLE auto-clear

Behaviour:
- Clocking/reset: single clock domain. When i_rst_n=0 at a clock edge: state=IDLE; all pos, vel, bounce_cnt and rest counter=0; all pulse outputs=0. All outputs are therefore 0 after reset.
- Priority per edge: reset > i_launch > i_clear > refresh update > hold.
- Launch, from any state: x_pos=i_launch_x-X_ORIGIN (W-bit wrap), y_pos=z_pos=0. Velocities load from i_vel_*. bounce_cnt=0, rest counter=0, state=FLIGHT. A held i_launch reloads every cycle, so no motion occurs while it is high.
- i_clear (no launch): state=IDLE; pos, vel and counters=0; no o_done pulse.
- IDLE: registers hold; i_refresh is ignored.
- FLIGHT, on i_refresh: x_pos+=x_vel and y_pos+=y_vel.
- FLIGHT drag, applied per axis to x and y: if |v| <= ACC then v=0, else v -= sign(v)*ACC.
- FLIGHT z: zn = z_pos+z_vel.
  - If zn >= 0: z_pos=zn, z_vel -= Z_ACC.
  - If zn < 0, bounce_cnt < MAX_BOUNCES and ((-z_vel)>>>BOUNCE_SHIFT) != 0: rebound. z_pos=0, z_vel=(-z_vel)>>>BOUNCE_SHIFT, bounce_cnt++, o_bounce=1.
  - Otherwise: final landing. z_pos=0, all velocities=0, state=REST, rest counter=0, o_landed=1; bounce_cnt increments saturating at MAX_BOUNCES.
- REST, on i_refresh: the rest counter increments, saturating at REST_FRAMES.
- REST exit: when counter==REST_FRAMES and i_hold=0, on the next i_refresh go to IDLE, zero all pos, o_done=1. With i_hold=1 the block stays in REST indefinitely, and the position is kept for collision.
- Arithmetic: all pos/vel sums wrap modulo 2^W with no saturation. Shifts are arithmetic.
- Latency: outputs are registered-state derived. Position changes are visible the cycle after the i_refresh edge.
- Pulses are exactly one clock wide and never assert in IDLE.

Test Plan:
- Reset: drive i_rst_n=0 with i_launch=1 for one edge -> all outputs 0, state IDLE; release -> launch takes effect next edge.
- Flight (W=16, FRAC=2, Z_ACC=3, X_ACC=1, MAX_BOUNCES=2), launch i_launch_x=1590, vx=4, vz=9, then refresh ticks:
  - Tick 1 -> x=4, z=9; tick 2 -> x=7, z=15; tick 3 -> x=9, z=18; tick 4 -> x=10, z=18.
  - x then stays 10 (vx saturated at 0), so o_x_pos=2.
- Bounce: continue the flight -> tick 7 gives z=0, vz=-12; tick 8 -> rebound with z=0, vz=6, o_bounce pulse, bounce_cnt=1.
- Second contact and landing: continue the flight -> second contact rebounds (bounce_cnt=2). The next contact -> o_landed pulse, state REST, all vel=0.
- Rest/hold: REST_FRAMES=60 with i_hold=1 over 100 ticks -> stays in REST, position held. Drop i_hold -> on the next tick o_done pulses, state IDLE, outputs 0.
- Simultaneity: i_launch and i_clear together mid-flight -> launch wins (FLIGHT, reloaded). i_clear alone in REST -> IDLE with no o_done. i_refresh with no launch in IDLE -> no change.
